// File: rtl/usb_tx_scheduler_if.sv
// Word handshakes between the audio and message requesters, the transmit scheduler
// and the FT245 bridge transmit port.
interface usb_tx_scheduler_if;
  logic [31:0] aud_data;
  logic        aud_valid;
  logic        aud_ready;
  logic [31:0] msg_data;
  logic        msg_valid;
  logic        msg_last;
  logic        msg_ready;
  logic [31:0] tx;
  logic        tx_en;
  logic        tx_ce;
  logic        in_packet;

  modport slave (
    input  aud_data, aud_valid, msg_data, msg_valid, msg_last, tx_ce,
    output aud_ready, msg_ready, tx, tx_en, in_packet
  );

  modport master (
    output aud_data, aud_valid, msg_data, msg_valid, msg_last, tx_ce,
    input  aud_ready, msg_ready, tx, tx_en, in_packet
  );
endinterface

// File: rtl/usb_tx_scheduler.sv
// Shares the FT245 32-bit transmit word between the audio stream (priority) and
// atomic message packets, with a bounded starvation counter for message progress.
module usb_tx_scheduler #(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  usb_tx_scheduler_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MSG  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [31:0]      tx_q, tx_d;
  logic             full_q, full_d;
  logic             slot_free_s;
  logic             msg_turn_s;
  logic             aud_rdy_s;
  logic             msg_rdy_s;

  assign slot_free_s = !full_q || bus.tx_ce;
  assign msg_turn_s  = !bus.aud_valid || (starve_q >= STARVE_LIM);

  // Arbitration in IDLE, atomic packet sequencing in MSG, starvation accounting.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    aud_rdy_s = 1'b0;
    msg_rdy_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slot_free_s && bus.msg_valid && msg_turn_s) begin
          msg_rdy_s = 1'b1;
          starve_d  = '0;
          if (bus.msg_last) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_MSG;
          end
        end else if (slot_free_s && bus.aud_valid) begin
          aud_rdy_s = 1'b1;
          if (!bus.msg_valid) begin
            starve_d = '0;
          end else if (starve_q >= STARVE_LIM) begin
            starve_d = STARVE_LIM;
          end else begin
            starve_d = starve_q + 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MSG: begin
        // Audio stays blocked even while the message source stalls mid-packet.
        msg_rdy_s = slot_free_s;
        if (slot_free_s && bus.msg_valid && bus.msg_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MSG;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output holding register: load on an accepted word, empty on a bare transfer.
  always_comb begin
    tx_d   = tx_q;
    full_d = full_q;
    if (aud_rdy_s && bus.aud_valid) begin
      tx_d   = bus.aud_data;
      full_d = 1'b1;
    end else if (msg_rdy_s && bus.msg_valid) begin
      tx_d   = bus.msg_data;
      full_d = 1'b1;
    end else if (full_q && bus.tx_ce) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // State, counter and output register update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      tx_q     <= 32'h0000_0000;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tx_q     <= tx_d;
      full_q   <= full_d;
    end
  end

  // Readies are forced low while reset is asserted.
  assign bus.aud_ready = aud_rdy_s & reset_n;
  assign bus.msg_ready = msg_rdy_s & reset_n;
  assign bus.tx        = tx_q;
  assign bus.tx_en     = full_q;
  assign bus.in_packet = (state_q == ST_MSG);

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Scoreboard bench for usb_tx_scheduler: directed test-plan scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_usb_tx_scheduler;
  localparam int SMAX = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  usb_tx_scheduler_if bus ();

  usb_tx_scheduler #(.STARVE_MAX(SMAX), .CNT_W(8)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] aud_q[$];
  logic [32:0] msg_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] want[$];

  bit          m_full;
  bit          m_in_pkt;
  int          m_starve;
  logic [31:0] m_tx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_full   = 1'b0;
    m_in_pkt = 1'b0;
    m_starve = 0;
    m_tx     = 32'h0000_0000;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic step(input bit a_en, input bit m_en, input bit ce);
    bit av, mv, ml, slot, msg_turn, gm, ga, exp_mr;
    logic [31:0] ad, md, dummy_w;
    logic [32:0] dummy_m;
    @(negedge clock);
    av = a_en && (aud_q.size() > 0);
    mv = m_en && (msg_q.size() > 0);
    ad = av ? aud_q[0] : $urandom;
    md = mv ? msg_q[0][31:0] : $urandom;
    ml = mv ? msg_q[0][32] : 1'($urandom_range(1, 0));
    bus.aud_valid = av;
    bus.aud_data  = ad;
    bus.msg_valid = mv;
    bus.msg_data  = md;
    bus.msg_last  = ml;
    bus.tx_ce     = ce;
    #1;
    slot     = !m_full || ce;
    msg_turn = m_in_pkt || !av || (m_starve == SMAX);
    gm       = slot && mv && msg_turn;
    ga       = slot && av && !m_in_pkt && !gm;
    exp_mr   = m_in_pkt ? slot : gm;
    chk("aud_ready", 32'(bus.aud_ready), 32'(ga));
    chk("msg_ready", 32'(bus.msg_ready), 32'(exp_mr));
    chk("tx_en", 32'(bus.tx_en), 32'(m_full));
    chk("tx", bus.tx, m_tx);
    chk("in_packet", 32'(bus.in_packet), 32'(m_in_pkt));
    if (gm) begin
      exp_q.push_back(md);
      m_tx     = md;
      m_full   = 1'b1;
      m_starve = 0;
      m_in_pkt = !ml;
      dummy_m  = msg_q.pop_front();
    end else if (ga) begin
      exp_q.push_back(ad);
      m_tx     = ad;
      m_full   = 1'b1;
      m_starve = mv ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
      dummy_w  = aud_q.pop_front();
    end else if (ce) begin
      m_full = 1'b0;
    end
  endtask

  task automatic drain(input string name, output int pk_cycles);
    int cyc;
    cyc       = 0;
    pk_cycles = 0;
    while (!(aud_q.size() == 0 && msg_q.size() == 0 && exp_q.size() == 0 && !m_full) && cyc < 300) begin
      step(1'b1, 1'b1, 1'b1);
      if (bus.in_packet) pk_cycles++;
      cyc++;
    end
    if (cyc >= 300) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d pending words expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_seq(input string name);
    chk({name, "_len"}, 32'(obs_q.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < obs_q.size(); i++) chk(name, obs_q[i], want[i]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n       = 1'b0;
    bus.aud_valid = 1'b1;
    bus.msg_valid = 1'b1;
    bus.msg_last  = 1'b0;
    #1;
    chk("rst_tx_en", 32'(bus.tx_en), 32'd0);
    chk("rst_tx", bus.tx, 32'h0000_0000);
    chk("rst_aud_ready", 32'(bus.aud_ready), 32'd0);
    chk("rst_msg_ready", 32'(bus.msg_ready), 32'd0);
    chk("rst_in_packet", 32'(bus.in_packet), 32'd0);
    model_reset();
    repeat (2) @(negedge clock);
    bus.aud_valid = 1'b0;
    bus.msg_valid = 1'b0;
    bus.tx_ce     = 1'b0;
    reset_n       = 1'b1;
  endtask

  // Monitor: every word leaving on the next edge is matched against the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clock);
      #2;
      if (reset_n && bus.tx_en && bus.tx_ce) begin
        obs_q.push_back(bus.tx);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_tx: got %h expected no word", bus.tx);
        end else begin
          chk("tx_order", bus.tx, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stim
    int pk;
    bus.aud_data  = 32'h0;
    bus.aud_valid = 1'b0;
    bus.msg_data  = 32'h0;
    bus.msg_valid = 1'b0;
    bus.msg_last  = 1'b0;
    bus.tx_ce     = 1'b0;
    model_reset();

    // Reset with both requesters waiting; audio must win first.
    aud_q.push_back(32'hA000_0001);
    msg_q.push_back({1'b1, 32'hC100_0001});
    do_reset();
    obs_q.delete();
    drain("init", pk);
    want.delete();
    want.push_back(32'hA000_0001);
    want.push_back(32'hC100_0001);
    check_seq("reset_first_audio");

    // Back-to-back audio streaming.
    obs_q.delete();
    for (int i = 1; i <= 4; i++) aud_q.push_back(32'hAB00_0000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (i > 0) chk("stream_tx_en", 32'(bus.tx_en), 32'd1);
    end
    drain("stream", pk);
    want.delete();
    for (int i = 1; i <= 4; i++) want.push_back(32'hAB00_0000 + 32'(i));
    check_seq("stream_seq");

    // Back-pressure: five stalled cycles with another word waiting.
    obs_q.delete();
    aud_q.push_back(32'hFEED_F00D);
    step(1'b1, 1'b0, 1'b1);
    aud_q.push_back(32'hAA55_AA55);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("bp_tx_hold", bus.tx, 32'hFEED_F00D);
      chk("bp_aud_ready", 32'(bus.aud_ready), 32'd0);
    end
    drain("bp", pk);
    want.delete();
    want.push_back(32'hFEED_F00D);
    want.push_back(32'hAA55_AA55);
    check_seq("bp_seq");

    // Starvation bound: eight audio words, then the whole packet.
    obs_q.delete();
    for (int i = 0; i < 20; i++) aud_q.push_back(32'hD000_0000 + 32'(i));
    msg_q.push_back({1'b0, 32'hC000_0001});
    msg_q.push_back({1'b1, 32'hC000_0002});
    drain("starve", pk);
    chk("starve_in_packet_cycles", 32'(pk), 32'd1);
    want.delete();
    for (int i = 0; i < 8; i++) want.push_back(32'hD000_0000 + 32'(i));
    want.push_back(32'hC000_0001);
    want.push_back(32'hC000_0002);
    for (int i = 8; i < 20; i++) want.push_back(32'hD000_0000 + 32'(i));
    check_seq("starve_seq");

    // Packet atomicity across a message-source gap.
    obs_q.delete();
    msg_q.push_back({1'b0, 32'hB000_0001});
    msg_q.push_back({1'b0, 32'hB000_0002});
    msg_q.push_back({1'b1, 32'hB000_0003});
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) aud_q.push_back(32'hE000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("atomic_aud_ready", 32'(bus.aud_ready), 32'd0);
    end
    drain("atomic", pk);
    want.delete();
    for (int i = 1; i <= 3; i++) want.push_back(32'hB000_0000 + 32'(i));
    for (int i = 0; i < 6; i++) want.push_back(32'hE000_0000 + 32'(i));
    check_seq("atomic_seq");

    // Reset in the middle of a four-word packet.
    obs_q.delete();
    for (int i = 1; i <= 4; i++) msg_q.push_back({(i == 4), 32'hF000_0000 + 32'(i)});
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("pre_rst_in_packet", 32'(bus.in_packet), 32'd1);
    aud_q.push_back(32'h9000_0001);
    aud_q.push_back(32'h9000_0002);
    do_reset();
    msg_q.delete();
    for (int i = 1; i <= 4; i++) msg_q.push_back({(i == 4), 32'hF000_0000 + 32'(i)});
    drain("midrst", pk);
    want.delete();
    want.push_back(32'hF000_0001);
    want.push_back(32'h9000_0001);
    want.push_back(32'h9000_0002);
    for (int i = 1; i <= 4; i++) want.push_back(32'hF000_0000 + 32'(i));
    check_seq("midrst_seq");

    // Random traffic against the reference model.
    for (int c = 0; c < 2000; c++) begin
      if (aud_q.size() < 2) aud_q.push_back($urandom);
      if (msg_q.size() == 0) begin
        int len;
        len = $urandom_range(4, 1);
        for (int k = 1; k <= len; k++) msg_q.push_back({(k == len), 32'($urandom)});
      end
      step($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 60, $urandom_range(99, 0) < 75);
    end
    drain("random", pk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
